// File: rtl/iorq_port_ctl.sv
// Z8S180 I/O cycle sequencer for a bank of on-FPGA ports: address decode,
// per-port read/write strobes, malformed-cycle flag and wrapping cycle counters.
module iorq_port_ctl #(
    parameter int                ADDR_W   = 8,
    parameter int                DEV_BITS = 2,
    parameter logic [ADDR_W-1:0] BASE     = 8'h40,
    parameter int                CNT_W    = 8,
    localparam int               NUM_DEV  = 2**DEV_BITS
) (
    input  logic                phi,
    input  logic                reset,
    input  logic                iorq,
    input  logic                rd,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                err_clr,
    output logic [NUM_DEV-1:0]  dev_sel,
    output logic                rd_tick,
    output logic                wr_tick,
    output logic [NUM_DEV-1:0]  rd_stb,
    output logic [NUM_DEV-1:0]  wr_stb,
    output logic                err,
    output logic [CNT_W-1:0]    rd_count,
    output logic [CNT_W-1:0]    wr_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DEV_BITS-1:0]   r_dev_q;
    logic                  r_err;
    logic [CNT_W-1:0]      r_rd_count;
    logic [CNT_W-1:0]      r_wr_count;

    logic                  w_hit;
    logic                  w_bad;
    logic                  w_valid;
    logic                  w_rd_tick;
    logic                  w_wr_tick;
    logic                  w_load_dev;
    logic [DEV_BITS-1:0]   w_port;

    assign w_port  = addr[DEV_BITS-1:0];
    assign w_hit   = (addr[ADDR_W-1:DEV_BITS] == BASE[ADDR_W-1:DEV_BITS]);
    assign w_bad   = rd && wr;
    assign w_valid = w_hit && (rd ^ wr);

    // State register: every update happens on the falling edge of phi.
    always_ff @(negedge phi) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (iorq && w_bad)        w_state_next = ST_ERR;
                else if (iorq && w_valid) w_state_next = ST_ONE;
                else if (iorq)            w_state_next = ST_DONE;
                else                      w_state_next = ST_IDLE;
            end
            ST_ONE, ST_DONE: begin
                if (!iorq)      w_state_next = ST_IDLE;
                else if (w_bad) w_state_next = ST_ERR;
                else            w_state_next = ST_DONE;
            end
            ST_ERR: begin
                if (!iorq)      w_state_next = ST_IDLE;
                else            w_state_next = ST_ERR;
            end
            default:            w_state_next = ST_IDLE;
        endcase
    end

    // Ticks are suppressed while reset is held, even though the state is IDLE.
    always_comb begin
        w_rd_tick  = 1'b0;
        w_wr_tick  = 1'b0;
        w_load_dev = 1'b0;
        if (reset) begin
            w_rd_tick  = (r_state == ST_IDLE) && iorq && rd && !wr && w_hit;
            w_wr_tick  = (r_state == ST_ONE) && iorq && wr && !rd;
            w_load_dev = (r_state == ST_IDLE) && iorq && w_valid && !w_bad;
        end
    end

    always_ff @(negedge phi) begin
        if (!reset) begin
            r_dev_q    <= '0;
            r_err      <= 1'b0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_load_dev) begin
                r_dev_q <= w_port;
            end
            if (iorq && w_bad) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
            if (w_rd_tick) begin
                r_rd_count <= r_rd_count + CNT_W'(1);
            end
            if (w_wr_tick) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
        end
    end

    // Read strobe follows the live address; write strobe uses the port latched at edge 1.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DEV; gi++) begin : g_port
            assign dev_sel[gi] = iorq && w_hit && (w_port == DEV_BITS'(gi));
            assign rd_stb[gi]  = w_rd_tick && (w_port == DEV_BITS'(gi));
            assign wr_stb[gi]  = w_wr_tick && (r_dev_q == DEV_BITS'(gi));
        end
    endgenerate

    assign rd_tick  = w_rd_tick;
    assign wr_tick  = w_wr_tick;
    assign err      = r_err;
    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_iorq_port_ctl.sv
// Self-checking bench for iorq_port_ctl: directed vector table, a wrap loop,
// and randomized I/O cycles checked against an edge-counting reference model.
module tb_iorq_port_ctl;

    logic       phi = 1'b1;
    logic       reset = 1'b0;
    logic       iorq = 1'b0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       err_clr = 1'b0;
    logic [3:0] dev_sel, rd_stb, wr_stb;
    logic       rd_tick, wr_tick, err;
    logic [7:0] rd_count, wr_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 phi = ~phi;

    iorq_port_ctl dut (
        .phi(phi), .reset(reset), .iorq(iorq), .rd(rd), .wr(wr),
        .addr(addr), .err_clr(err_clr), .dev_sel(dev_sel),
        .rd_tick(rd_tick), .wr_tick(wr_tick), .rd_stb(rd_stb),
        .wr_stb(wr_stb), .err(err), .rd_count(rd_count), .wr_count(wr_count)
    );

    typedef struct {
        logic       rst_n, iorq, rd, wr;
        logic [7:0] addr;
        logic       clr;
        logic [3:0] e_rd, e_wr, e_sel;
        logic       e_err;
        logic [7:0] e_rdc, e_wrc;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(input logic rs, input logic io, input logic r,
                                input logic w, input logic [7:0] a, input logic c,
                                input logic [3:0] er, input logic [3:0] ew,
                                input logic [3:0] es, input logic ee,
                                input logic [7:0] erc, input logic [7:0] ewc);
        vec_t v;
        v.rst_n = rs; v.iorq = io; v.rd = r; v.wr = w; v.addr = a; v.clr = c;
        v.e_rd = er; v.e_wr = ew; v.e_sel = es; v.e_err = ee;
        v.e_rdc = erc; v.e_wrc = ewc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rs, input logic io, input logic r, input logic w,
                         input logic [7:0] a, input logic c);
        @(posedge phi);
        reset = rs; iorq = io; rd = r; wr = w; addr = a; err_clr = c;
        #1;
    endtask

    task automatic pass_edge();
        @(negedge phi);
        #1;
    endtask

    // Reference model: counts falling edges seen inside the current iorq cycle.
    int         m_k;
    bit         m_first_ok;
    logic [1:0] m_dev;
    logic [7:0] m_rdc, m_wrc;
    logic       m_err;

    task automatic model_step(input logic rs, input logic io, input logic r, input logic w,
                              input logic [7:0] a, input logic c);
        bit         hit, t_rd, t_wr;
        logic [3:0] e_sel, e_rs, e_ws;
        hit   = (a[7:2] == 6'h10);
        t_rd  = rs && io && (m_k == 0) && r && !w && hit;
        t_wr  = rs && io && (m_k == 1) && m_first_ok && w && !r;
        e_sel = (io && hit) ? (4'b0001 << a[1:0]) : 4'b0000;
        e_rs  = t_rd ? (4'b0001 << a[1:0]) : 4'b0000;
        e_ws  = t_wr ? (4'b0001 << m_dev) : 4'b0000;
        drive(rs, io, r, w, a, c);
        chk("rnd_dev_sel", 32'(dev_sel), 32'(e_sel));
        chk("rnd_rd_stb", 32'(rd_stb), 32'(e_rs));
        chk("rnd_wr_stb", 32'(wr_stb), 32'(e_ws));
        chk("rnd_rd_tick", 32'(rd_tick), 32'(t_rd));
        chk("rnd_wr_tick", 32'(wr_tick), 32'(t_wr));
        pass_edge();
        if (!rs) begin
            m_k = 0; m_first_ok = 0; m_rdc = 0; m_wrc = 0; m_err = 0;
        end else begin
            if (t_rd) m_rdc = m_rdc + 8'd1;
            if (t_wr) m_wrc = m_wrc + 8'd1;
            if (io && r && w) m_err = 1'b1;
            else if (c)       m_err = 1'b0;
            if (io) begin
                if (m_k == 0) begin
                    m_first_ok = hit && (r ^ w);
                    m_dev      = a[1:0];
                end
                if (m_k < 2) m_k++;
            end else begin
                m_k = 0;
            end
        end
        chk("rnd_err", 32'(err), 32'(m_err));
        chk("rnd_rd_count", 32'(rd_count), 32'(m_rdc));
        chk("rnd_wr_count", 32'(wr_count), 32'(m_wrc));
    endtask

    initial begin
        //               rs io rd wr addr  clr  e_rd     e_wr     e_sel    err rdc wrc
        tbl[0]  = mk(0, 1, 1, 0, 8'h41, 0, 4'b0000, 4'b0000, 4'b0010, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 0, 8'h41, 0, 4'b0000, 4'b0000, 4'b0010, 0, 0, 0);
        tbl[2]  = mk(1, 1, 1, 0, 8'h41, 0, 4'b0010, 4'b0000, 4'b0010, 0, 1, 0);
        tbl[3]  = mk(1, 0, 0, 0, 8'h41, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0);
        tbl[4]  = mk(1, 1, 1, 0, 8'h42, 0, 4'b0100, 4'b0000, 4'b0100, 0, 2, 0);
        tbl[5]  = mk(1, 1, 1, 0, 8'h42, 0, 4'b0000, 4'b0000, 4'b0100, 0, 2, 0);
        tbl[6]  = mk(1, 1, 1, 0, 8'h42, 0, 4'b0000, 4'b0000, 4'b0100, 0, 2, 0);
        tbl[7]  = mk(1, 0, 0, 0, 8'h42, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2, 0);
        tbl[8]  = mk(1, 1, 0, 1, 8'h43, 0, 4'b0000, 4'b0000, 4'b1000, 0, 2, 0);
        tbl[9]  = mk(1, 1, 0, 1, 8'h40, 0, 4'b0000, 4'b1000, 4'b0001, 0, 2, 1);
        tbl[10] = mk(1, 1, 0, 1, 8'h40, 0, 4'b0000, 4'b0000, 4'b0001, 0, 2, 1);
        tbl[11] = mk(1, 0, 0, 0, 8'h40, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2, 1);
        tbl[12] = mk(1, 1, 1, 0, 8'h80, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2, 1);
        tbl[13] = mk(1, 1, 1, 0, 8'h80, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2, 1);
        tbl[14] = mk(1, 0, 0, 0, 8'h80, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2, 1);
        tbl[15] = mk(1, 1, 1, 0, 8'h40, 0, 4'b0001, 4'b0000, 4'b0001, 0, 3, 1);
        tbl[16] = mk(1, 0, 0, 0, 8'h40, 0, 4'b0000, 4'b0000, 4'b0000, 0, 3, 1);
        tbl[17] = mk(1, 1, 1, 1, 8'h40, 0, 4'b0000, 4'b0000, 4'b0001, 1, 3, 1);
        tbl[18] = mk(1, 1, 1, 1, 8'h40, 0, 4'b0000, 4'b0000, 4'b0001, 1, 3, 1);
        tbl[19] = mk(1, 1, 1, 0, 8'h40, 0, 4'b0000, 4'b0000, 4'b0001, 1, 3, 1);
        tbl[20] = mk(1, 0, 0, 0, 8'h40, 0, 4'b0000, 4'b0000, 4'b0000, 1, 3, 1);
        tbl[21] = mk(1, 0, 0, 0, 8'h40, 1, 4'b0000, 4'b0000, 4'b0000, 0, 3, 1);
        tbl[22] = mk(1, 1, 1, 1, 8'h41, 1, 4'b0000, 4'b0000, 4'b0010, 1, 3, 1);
        tbl[23] = mk(1, 0, 0, 0, 8'h41, 0, 4'b0000, 4'b0000, 4'b0000, 1, 3, 1);
        tbl[24] = mk(1, 1, 0, 0, 8'h40, 0, 4'b0000, 4'b0000, 4'b0001, 1, 3, 1);
        tbl[25] = mk(1, 1, 0, 1, 8'h40, 0, 4'b0000, 4'b0000, 4'b0001, 1, 3, 1);
        tbl[26] = mk(1, 0, 0, 0, 8'h40, 1, 4'b0000, 4'b0000, 4'b0000, 0, 3, 1);
        tbl[27] = mk(1, 1, 1, 0, 8'h42, 0, 4'b0100, 4'b0000, 4'b0100, 0, 4, 1);
        tbl[28] = mk(1, 1, 1, 1, 8'h42, 0, 4'b0000, 4'b0000, 4'b0100, 1, 4, 1);
        tbl[29] = mk(1, 0, 0, 0, 8'h42, 0, 4'b0000, 4'b0000, 4'b0000, 1, 4, 1);

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].rst_n, tbl[i].iorq, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].clr);
            chk($sformatf("tbl%0d_dev_sel", i), 32'(dev_sel), 32'(tbl[i].e_sel));
            chk($sformatf("tbl%0d_rd_stb", i), 32'(rd_stb), 32'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_wr_stb", i), 32'(wr_stb), 32'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_rd_tick", i), 32'(rd_tick), 32'(|tbl[i].e_rd));
            chk($sformatf("tbl%0d_wr_tick", i), 32'(wr_tick), 32'(|tbl[i].e_wr));
            pass_edge();
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_rd_count", i), 32'(rd_count), 32'(tbl[i].e_rdc));
            chk($sformatf("tbl%0d_wr_count", i), 32'(wr_count), 32'(tbl[i].e_wrc));
            $display("vec %0d: iorq=%b rd=%b wr=%b addr=%h rd_stb=%b wr_stb=%b err=%b rdc=%0d wrc=%0d",
                     i, tbl[i].iorq, tbl[i].rd, tbl[i].wr, tbl[i].addr, rd_stb, wr_stb,
                     err, rd_count, wr_count);
        end

        // 256 back-to-back reads, one idle edge apart: counter wraps to where it began.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            logic [3:0] e;
            a = 8'h40 + 8'(i % 4);
            e = 4'b0001 << (i % 4);
            drive(1, 1, 1, 0, a, 0);
            chk("b2b_rd_stb", 32'(rd_stb), 32'(e));
            chk("b2b_wr_tick", 32'(wr_tick), 32'd0);
            pass_edge();
            drive(1, 0, 0, 0, a, 0);
            chk("b2b_idle_rd_tick", 32'(rd_tick), 32'd0);
            pass_edge();
        end
        chk("b2b_rd_count_wrap", 32'(rd_count), 32'd4);
        $display("b2b: 256 reads done, rd_count=%0d", rd_count);

        // Randomized I/O cycles against the reference model, starting from reset.
        m_k = 0; m_first_ok = 0; m_dev = 0; m_rdc = 0; m_wrc = 0; m_err = 0;
        model_step(0, 0, 0, 0, 8'h00, 0);
        model_step(0, 0, 0, 0, 8'h00, 0);
        for (int c = 0; c < 200; c++) begin
            int         kind, len, idle;
            logic [7:0] a;
            logic       r, w;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 4);
            idle = $urandom_range(1, 2);
            a    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h40 + 8'($urandom_range(0, 3));
            r    = (kind <= 3) || (kind == 8);
            w    = (kind >= 4 && kind <= 7) || (kind == 8);
            for (int j = 0; j < len; j++) begin
                logic rs, rr, ww, cl;
                rs = ($urandom_range(0, 39) != 0);
                rr = r; ww = w;
                if ($urandom_range(0, 9) == 0) begin rr = 1; ww = 1; end
                if (j > 0 && $urandom_range(0, 3) == 0) a = 8'h40 + 8'($urandom_range(0, 3));
                cl = ($urandom_range(0, 7) == 0);
                model_step(rs, 1, rr, ww, a, cl);
            end
            for (int j = 0; j < idle; j++) begin
                model_step(1, 0, 1'($urandom), 1'($urandom), 8'($urandom),
                           ($urandom_range(0, 3) == 0));
            end
            $display("rnd cycle %0d: kind=%0d len=%0d addr=%h rdc=%0d wrc=%0d err=%b",
                     c, kind, len, a, rd_count, wr_count, err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
